// File: rtl/alu_cmd_pipe_if.sv
// alu_cmd_pipe_if: command, ALU and result signals of the ALU command pipe
// slave  = pipe side: takes commands and ALU outputs, drives ALU inputs and results
// master = environment side: offers commands, models the ALU, consumes results
interface alu_cmd_pipe_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_sel;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       in_use_acc;
  logic [2:0] alu_sel;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_result;
  logic       alu_carry;
  logic       alu_overflow;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic       out_zero;
  logic       out_carry;
  logic       out_overflow;
  modport slave (
    input  in_valid, in_sel, in_a, in_b, in_use_acc, alu_result, alu_carry, alu_overflow, out_ready,
    output in_ready, alu_sel, alu_a, alu_b, out_valid, out_result, out_zero, out_carry, out_overflow
  );
  modport master (
    output in_valid, in_sel, in_a, in_b, in_use_acc, alu_result, alu_carry, alu_overflow, out_ready,
    input  in_ready, alu_sel, alu_a, alu_b, out_valid, out_result, out_zero, out_carry, out_overflow
  );
endinterface

// File: rtl/alu_cmd_pipe.sv
// alu_cmd_pipe: FIFO-buffered command front end for a 4-bit combinational ALU with registered result stage
// clk, rst : clock and synchronous active-high reset
// bus      : command push (in_*), ALU drive/return (alu_*), result handshake (out_*)
module alu_cmd_pipe #(
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  alu_cmd_pipe_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef struct packed {
    logic [2:0] sel;
    logic [3:0] a;
    logic [3:0] b;
    logic       use_acc;
  } cmd_t;
  cmd_t          r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic [3:0]    r_acc;
  logic          r_out_valid;
  logic [3:0]    r_result;
  logic          r_zero, r_carry, r_ovf;
  cmd_t          w_head;
  logic          w_empty, w_full, w_push, w_issue, w_arith;
  always_comb begin
    w_head  = r_mem[r_rp];
    w_empty = r_cnt == '0;
    w_full  = r_cnt == FULL;
    w_push  = bus.in_valid & ~w_full;
    w_issue = ~w_empty & (~r_out_valid | bus.out_ready);
    // carry/overflow are only meaningful for add (000) and sub (001)
    w_arith = bus.alu_sel[2:1] == 2'b00;
  end
  assign bus.in_ready     = ~w_full;
  assign bus.alu_sel      = w_empty ? 3'd0 : w_head.sel;
  assign bus.alu_a        = w_empty ? 4'd0 : w_head.use_acc ? r_acc : w_head.a;
  assign bus.alu_b        = w_empty ? 4'd0 : w_head.b;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_result   = r_result;
  assign bus.out_zero     = r_zero;
  assign bus.out_carry    = r_carry;
  assign bus.out_overflow = r_ovf;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= cmd_t'{bus.in_sel, bus.in_a, bus.in_b, bus.in_use_acc};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_issue);
      if (w_issue) begin
        r_rp        <= r_rp + AW'(1);
        r_acc       <= bus.alu_result;
        r_out_valid <= 1'b1;
        r_result    <= bus.alu_result;
        r_zero      <= bus.alu_result == 4'd0;
        r_carry     <= w_arith & bus.alu_carry;
        r_ovf       <= w_arith & bus.alu_overflow;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_cmd_pipe.sv
// tb_alu_cmd_pipe: scoreboard bench for alu_cmd_pipe with a behavioural 4-bit ALU
module tb_alu_cmd_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  alu_cmd_pipe_if bus ();
  alu_cmd_pipe #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_chk = 0, n_pass = 0, n_acc = 0, n_out = 0;
  logic [6:0] sb [$];
  logic [3:0] acc_m = 4'd0;
  logic       hold_prev = 1'b0;
  logic [6:0] held;
  // returns {result, carry, overflow}; non-arith ops return junk flags the pipe must mask
  function automatic logic [5:0] alu_f(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] t;
    logic [3:0] r;
    case (s)
      3'd0: begin t = {1'b0, a} + {1'b0, b}; r = t[3:0]; return {r, t[4], (a[3] == b[3]) && (r[3] != a[3])}; end
      3'd1: begin t = {1'b0, a} - {1'b0, b}; r = t[3:0]; return {r, t[4], (a[3] != b[3]) && (r[3] != a[3])}; end
      3'd2: return {a & b, a[0] ^ b[1], b[0]};
      3'd3: return {a | b, a[0] ^ b[1], b[0]};
      3'd4: return {a ^ b, a[0] ^ b[1], b[0]};
      3'd5: return {~a, a[0] ^ b[1], b[0]};
      3'd6: return {(a < b) ? 4'd1 : 4'd0, a[0] ^ b[1], b[0]};
      default: return {(a == b) ? 4'd1 : 4'd0, a[0] ^ b[1], b[0]};
    endcase
  endfunction
  always_comb {bus.alu_result, bus.alu_carry, bus.alu_overflow} = alu_f(bus.alu_sel, bus.alu_a, bus.alu_b);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask
  task automatic step(input logic v, input logic [2:0] s, input logic [3:0] a, input logic [3:0] b,
                      input logic u, input logic r);
    logic [6:0] cur;
    logic [5:0] f;
    logic [3:0] aa;
    @(negedge clk);
    bus.in_valid = v; bus.in_sel = s; bus.in_a = a; bus.in_b = b; bus.in_use_acc = u; bus.out_ready = r;
    #1;
    cur = {bus.out_result, bus.out_zero, bus.out_carry, bus.out_overflow};
    if (hold_prev) chk("hold", {bus.out_valid, cur}, {1'b1, held});
    hold_prev = bus.out_valid & ~bus.out_ready;
    held = cur;
    if (bus.out_valid && bus.out_ready) begin
      n_out++;
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) chk("result", cur, sb.pop_front());
    end
    if (v && bus.in_ready) begin
      n_acc++;
      aa = u ? acc_m : a;
      f = alu_f(s, aa, b);
      acc_m = f[5:2];
      sb.push_back({f[5:2], f[5:2] == 4'd0, f[1:0] & {2{s[2:1] == 2'b00}}});
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 4'd0, 4'd0, 1'b0, 1'b1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int a0, o0, cyc;
    bus.in_valid = 0; bus.in_sel = 0; bus.in_a = 0; bus.in_b = 0; bus.in_use_acc = 0; bus.out_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_out", {bus.out_result, bus.out_zero, bus.out_carry, bus.out_overflow}, 0);
    rst = 1'b0;
    // 7+1: latency and flags
    step(1'b1, 3'd0, 4'd7, 4'd1, 1'b0, 1'b1);
    step(1'b0, 3'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    chk("lat_e0", bus.out_valid, 0);
    step(1'b0, 3'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    chk("lat_e1", bus.out_valid, 1);
    chk("t1_out", {bus.out_result, bus.out_zero, bus.out_carry, bus.out_overflow}, {4'd8, 1'b0, 1'b0, 1'b1});
    idle(2);
    // F+1 wraps to zero with carry, then compare 2<9
    step(1'b1, 3'd0, 4'hF, 4'd1, 1'b0, 1'b1);
    step(1'b1, 3'd6, 4'd2, 4'd9, 1'b0, 1'b1);
    step(1'b0, 3'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    chk("t2_add", {bus.out_result, bus.out_zero, bus.out_carry, bus.out_overflow}, {4'd0, 1'b1, 1'b1, 1'b0});
    step(1'b0, 3'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    chk("t2_cmp", {bus.out_result, bus.out_zero, bus.out_carry, bus.out_overflow}, {4'd1, 1'b0, 1'b0, 1'b0});
    idle(2);
    // accumulator chain: 2+3=5, acc-1=4, then acc+0 must give 4
    step(1'b1, 3'd0, 4'd2, 4'd3, 1'b0, 1'b1);
    step(1'b1, 3'd1, 4'd9, 4'd1, 1'b1, 1'b1);
    step(1'b0, 3'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    chk("t3_first", bus.out_result, 4'd5);
    step(1'b0, 3'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    chk("t3_second", bus.out_result, 4'd4);
    step(1'b1, 3'd0, 4'd0, 4'd0, 1'b1, 1'b1);
    idle(3);
    chk("t3_acc", bus.out_result, 4'd4);
    // backpressure: 5 accepted, 6th refused, then 5 results back-to-back
    a0 = n_acc;
    for (int i = 0; i < 6; i++) step(1'b1, 3'(i), 4'(i + 3), 4'(2 * i), 1'b0, 1'b0);
    chk("bp_ready", bus.in_ready, 0);
    chk("bp_acc", n_acc - a0, 5);
    o0 = n_out;
    idle(5);
    chk("bp_out", n_out - o0, 5);
    idle(2);
    chk("bp_empty", sb.size(), 0);
    // reset with 1 held result and 3 queued commands
    for (int i = 0; i < 4; i++) step(1'b1, 3'd0, 4'(i + 1), 4'd2, 1'b0, 1'b0);
    step(1'b0, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    chk("pre_rst_valid", bus.out_valid, 1);
    @(negedge clk);
    rst = 1'b1; bus.in_valid = 1'b0;
    sb.delete(); acc_m = 4'd0; hold_prev = 1'b0;
    @(negedge clk); #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_ready", bus.in_ready, 1);
    rst = 1'b0;
    o0 = n_out;
    step(1'b1, 3'd0, 4'hA, 4'd3, 1'b1, 1'b1);
    idle(8);
    chk("post_rst_outs", n_out - o0, 1);
    chk("post_rst_acc", bus.out_result, 4'd3);
    // random traffic against the scoreboard
    a0 = n_acc;
    cyc = 0;
    while (n_acc - a0 < 1000 && cyc < 20000) begin
      step(1'($urandom_range(0, 1)), 3'($urandom), 4'($urandom), 4'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
      cyc++;
    end
    chk("rand_acc", n_acc - a0, 1000);
    idle(12);
    chk("rand_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
